// File: rtl/filter_coef_ctrl.sv
// 5x5 filter coefficient controller: shadow-loads a kernel word by word and
// swaps it into the active kernel only on a frame boundary.
module filter_coef_ctrl #(
    parameter int COEF_WIDTH = 8,
    parameter int NUM_TAPS   = 25
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               i_load_start,
    input  logic                               i_coef_valid,
    input  logic signed [COEF_WIDTH-1:0]       i_coef_data,
    output logic                               o_coef_ready,
    input  logic                               i_frame_start,
    output logic [NUM_TAPS*COEF_WIDTH-1:0]     o_coef,
    output logic signed [COEF_WIDTH+4:0]       o_coef_sum,
    output logic                               o_pending,
    output logic                               o_busy,
    output logic                               o_err
);

    localparam int SUMW = COEF_WIDTH + 5;
    localparam int CNTW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PENDING
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [CNTW-1:0]                r_cnt;
    logic signed [COEF_WIDTH-1:0]   r_shadow [NUM_TAPS];
    logic signed [SUMW-1:0]         r_ssum;
    logic signed [SUMW-1:0]         r_sum;
    logic [NUM_TAPS*COEF_WIDTH-1:0] r_coef;
    logic                           r_err;

    logic                           w_accept;
    logic                           w_last;
    logic                           w_swap;
    logic signed [SUMW-1:0]         w_data_ext;

    // A restart wins over a word arriving in the same cycle.
    assign w_accept   = (r_state == LOAD) && i_coef_valid && !i_load_start;
    assign w_last     = w_accept && (r_cnt == LAST);
    assign w_swap     = (r_state == PENDING) && i_frame_start && !i_load_start;
    assign w_data_ext = {{5{i_coef_data[COEF_WIDTH-1]}}, i_coef_data};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_load_start) w_next = LOAD;
            end
            LOAD: begin
                if (i_load_start)  w_next = LOAD;
                else if (w_last)   w_next = PENDING;
            end
            PENDING: begin
                if (i_load_start)       w_next = LOAD;
                else if (i_frame_start) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_ssum <= '0;
            r_sum  <= '0;
            r_coef <= '0;
            r_err  <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            if (i_load_start) begin
                r_cnt  <= '0;
                r_ssum <= '0;
                if (r_state == LOAD) r_err <= 1'b1;
            end else if (w_accept) begin
                r_shadow[r_cnt] <= i_coef_data;
                r_ssum          <= r_ssum + w_data_ext;
                r_cnt           <= w_last ? '0 : r_cnt + CNTW'(1);
            end
            if (w_swap) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    r_coef[k*COEF_WIDTH +: COEF_WIDTH] <= r_shadow[k];
                end
                r_sum <= r_ssum;
            end
        end
    end

    assign o_coef_ready = (r_state == LOAD);
    assign o_busy       = (r_state == LOAD);
    assign o_pending    = (r_state == PENDING);
    assign o_coef       = r_coef;
    assign o_coef_sum   = r_sum;
    assign o_err        = r_err;

endmodule

// File: tb/tb_filter_coef_ctrl.sv
// Bench for filter_coef_ctrl: directed kernel scenarios plus random traffic
// checked every cycle against a queue-based model of the kernel flow.
module tb_filter_coef_ctrl;

    localparam int CW = 8;
    localparam int NT = 25;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 i_load_start = 1'b0;
    logic                 i_coef_valid = 1'b0;
    logic [CW-1:0]        i_coef_data = '0;
    logic                 i_frame_start = 1'b0;
    logic                 o_coef_ready;
    logic [NT*CW-1:0]     o_coef;
    logic signed [CW+4:0] o_coef_sum;
    logic                 o_pending;
    logic                 o_busy;
    logic                 o_err;

    int tests = 0;
    int fails = 0;

    filter_coef_ctrl #(.COEF_WIDTH(CW), .NUM_TAPS(NT)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_load_start (i_load_start),
        .i_coef_valid (i_coef_valid),
        .i_coef_data  (i_coef_data),
        .o_coef_ready (o_coef_ready),
        .i_frame_start(i_frame_start),
        .o_coef       (o_coef),
        .o_coef_sum   (o_coef_sum),
        .o_pending    (o_pending),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    // Model: loading / pending flags, a queue of accepted words, active kernel
    bit m_load = 0;
    bit m_pend = 0;
    bit m_err  = 0;
    int m_q[$];
    int m_act[NT];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_load = 0;
            m_pend = 0;
            m_err  = 0;
            m_q.delete();
            for (int k = 0; k < NT; k++) m_act[k] = 0;
        end else if (i_load_start) begin
            if (m_load) m_err = 1;
            m_load = 1;
            m_pend = 0;
            m_q.delete();
        end else if (m_load) begin
            if (i_coef_valid) begin
                m_q.push_back(int'($signed(i_coef_data)));
                if (m_q.size() == NT) begin
                    m_load = 0;
                    m_pend = 1;
                end
            end
        end else if (m_pend && i_frame_start) begin
            for (int k = 0; k < NT; k++) m_act[k] = m_q[k];
            m_pend = 0;
        end
    end

    always @(negedge clk) begin
        logic [NT*CW-1:0] ev;
        int es;
        es = 0;
        for (int k = 0; k < NT; k++) begin
            ev[k*CW +: CW] = CW'(m_act[k]);
            es += m_act[k];
        end
        tests++;
        if (o_coef !== ev || int'(o_coef_sum) != es || o_coef_ready !== m_load ||
            o_busy !== m_load || o_pending !== m_pend || o_err !== m_err) begin
            fails++;
            $display("FAIL cycle_cmp t=%0t coef=%h exp=%h sum=%0d exp=%0d rdy/busy/pend/err=%b%b%b%b exp=%b%b%b%b",
                     $time, o_coef, ev, o_coef_sum, es, o_coef_ready, o_busy,
                     o_pending, o_err, m_load, m_load, m_pend, m_err);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [CW-1:0] b);
        logic [NT*CW-1:0] e;
        e = {NT{b}};
        tests++;
        if (o_coef !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, o_coef, e);
        end
    endtask

    task automatic cyc(input bit ls, input bit v, input bit fs, input logic [CW-1:0] d);
        @(negedge clk);
        i_load_start  = ls;
        i_coef_valid  = v;
        i_frame_start = fs;
        i_coef_data   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0);
    endtask

    task automatic load(input int base, input int step, input bit fs_last);
        cyc(1, 0, 0, '0);
        for (int k = 0; k < NT; k++) begin
            cyc(0, 1, (k == NT - 1) && fs_last, CW'(base + k * step));
        end
    endtask

    initial begin
        idle(3);
        chk("reset_coef", longint'(o_coef == '0), 1);
        chk("reset_sum", o_coef_sum, 0);
        chk("reset_flags", {o_coef_ready, o_busy, o_pending, o_err}, 0);
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        // ramp kernel 1..25
        load(1, 1, 0);
        cyc(0, 0, 1, '0);
        idle(1);
        chk("ramp_tap0", o_coef[7:0], 1);
        chk("ramp_tap24", o_coef[199:192], 25);
        chk("ramp_sum", o_coef_sum, 325);
        chk("ramp_pending", o_pending, 0);

        // all -128
        load(-128, 0, 0);
        cyc(0, 0, 1, '0);
        idle(1);
        chk("neg_sum", o_coef_sum, -3200);
        chk_all("neg_taps", 8'h80);

        // aborted load then full load of 2s
        cyc(1, 0, 0, '0);
        for (int k = 0; k < 10; k++) cyc(0, 1, 0, 8'd7);
        load(2, 0, 0);
        cyc(0, 0, 1, '0);
        idle(1);
        chk("abort_err", o_err, 1);
        chk_all("abort_taps", 8'd2);
        chk("abort_sum", o_coef_sum, 50);

        // frame pulse coincident with final tap is ignored
        load(3, 0, 1);
        idle(1);
        chk_all("coincide_hold", 8'd2);
        chk("coincide_pending", o_pending, 1);
        cyc(0, 0, 1, '0);
        idle(1);
        chk_all("coincide_swap", 8'd3);
        chk("coincide_sum", o_coef_sum, 75);

        // load_start beats frame_start in PENDING
        load(4, 0, 0);
        cyc(1, 0, 1, '0);
        idle(1);
        chk("prio_busy", o_busy, 1);
        chk("prio_pending", o_pending, 0);
        chk_all("prio_hold", 8'd3);
        for (int k = 0; k < NT; k++) cyc(0, 1, 0, 8'd5);
        cyc(0, 0, 1, '0);
        idle(1);
        chk_all("prio_swap", 8'd5);

        // asynchronous reset mid-load
        cyc(1, 0, 0, '0);
        for (int k = 0; k < 12; k++) cyc(0, 1, 0, 8'd9);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_coef", longint'(o_coef == '0), 1);
        chk("arst_sum", o_coef_sum, 0);
        chk("arst_flags", {o_coef_ready, o_busy, o_pending, o_err}, 0);
        idle(2);
        @(negedge clk);
        rstn = 1'b1;
        cyc(0, 0, 1, '0);
        idle(1);
        chk("arst_noswap", longint'(o_coef == '0), 1);
        chk("arst_nopend", o_pending, 0);

        // random traffic, checked every cycle by the compare process
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(59) == 0, $urandom_range(3) != 0,
                $urandom_range(7) == 0, CW'($urandom));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter_coef_ctrl.md
FILTER_COEF_CTRL -- requirements
Module: filter_coef_ctrl

Interface
REQ-001 SHALL have parameter COEF_WIDTH, default 8: signed coefficient width.
REQ-002 SHALL have parameter NUM_TAPS, default 25: taps per kernel (5x5, raster order 00..44).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_load_start  input  1  one-cycle pulse: begin loading a new kernel.
REQ-006 SHALL have port i_coef_valid  input  1  coefficient word valid.
REQ-007 SHALL have port i_coef_data  input  COEF_WIDTH  signed coefficient word.
REQ-008 SHALL have port o_coef_ready  output  1  controller accepts a word this cycle.
REQ-009 SHALL have port i_frame_start  input  1  one-cycle frame-boundary pulse (vsync).
REQ-010 SHALL have port o_coef  output  NUM_TAPS*COEF_WIDTH  active kernel; tap k at bits [k*COEF_WIDTH +: COEF_WIDTH].
REQ-011 SHALL have port o_coef_sum  output  COEF_WIDTH+5  signed sum of active kernel taps.
REQ-012 SHALL have port o_pending  output  1  complete shadow kernel awaiting swap.
REQ-013 SHALL have port o_busy  output  1  load in progress.
REQ-014 SHALL have port o_err  output  1  sticky: load aborted by restart.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, PENDING.
REQ-016 SHALL assert o_coef_ready exactly when state is LOAD; o_busy equals (state==LOAD).
REQ-017 SHALL accept a word only on i_coef_valid && o_coef_ready; word count n written to shadow tap n, n counting 0..NUM_TAPS-1.
REQ-018 SHALL transition IDLE->LOAD or PENDING->LOAD on i_load_start, clearing tap counter and shadow sum to 0; a pending shadow kernel is discarded and o_pending cleared.
REQ-019 SHALL, on i_load_start in LOAD, restart at tap 0, clear shadow sum, and set o_err.
REQ-020 SHALL accumulate shadow sum as signed, sign-extended COEF_WIDTH+5 bits; no overflow possible for 25 taps.
REQ-021 SHALL transition LOAD->PENDING on the cycle the tap NUM_TAPS-1 word is accepted; o_pending high from the next cycle.
REQ-022 SHALL, in PENDING with i_frame_start, copy shadow taps to o_coef and shadow sum to o_coef_sum, clear o_pending, go IDLE; outputs update the cycle after the pulse.
REQ-023 SHALL ignore i_frame_start in IDLE and LOAD; active kernel never changes mid-frame or from a partial load.
REQ-024 SHALL give i_load_start priority over i_frame_start in PENDING (no swap; new load begins).
REQ-025 SHALL ignore i_frame_start coinciding with acceptance of the final tap; swap occurs on the next pulse.
REQ-026 SHALL ignore i_coef_valid outside LOAD; words are not buffered.
REQ-027 SHALL clear o_err only by reset.
REQ-028 SHALL register all outputs; no combinational input-to-output path except none (o_coef_ready is state-decoded).

Reset
REQ-029 SHALL, on rstn low, asynchronously set state IDLE, tap counter 0, o_coef all 0, o_coef_sum 0, shadow taps 0, o_pending 0, o_busy 0, o_coef_ready 0, o_err 0.
REQ-030 SHALL, on reset mid-LOAD or mid-PENDING, discard the shadow kernel; no swap follows deassertion.

Verification
REQ-031 Load taps 1..25 (tap k = k+1), then i_frame_start -> cycle after pulse o_coef tap0=1, tap24=25, o_coef_sum=325, o_pending=0.
REQ-032 Load 25 taps all -128, frame_start -> o_coef_sum = -3200, every tap 0x80.
REQ-033 i_load_start, 10 words, i_load_start again, 25 words of 2, frame_start -> o_err=1, all taps 2, o_coef_sum=50.
REQ-034 Complete load, i_frame_start same cycle as tap 24 accept -> o_coef unchanged; next frame_start -> swap.
REQ-035 PENDING with i_load_start and i_frame_start same cycle -> no swap, o_busy=1, o_pending=0, o_coef unchanged.
REQ-036 rstn low after 12 accepted words -> all outputs 0 asynchronously; later frame_start produces no swap.
